uram_stream_reader: RTL and testbench

Read-side sequencer for the simple-dual-port UltraRAM buffer. It drives the memory's port B (enable, output-register enable, address) to fetch a contiguous run of 72-bit words. It absorbs the fixed memory read latency in a credit-controlled FIFO and presents the data as a valid/ready stream with a last-beat marker. It sits directly downstream of the UltraRAM and consumes everything its port B produces.

---
 rtl/uram_stream_reader_if.sv | 33 +++
 rtl/uram_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_uram_stream_reader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uram_stream_reader_if.sv
// Port-B read bus, transfer control and output stream of the UltraRAM read sequencer.
// master = sequencer side, slave = memory/consumer/controller side.
interface uram_stream_reader_if #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 72
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic              busy;
   logic              done;
   logic              mem_enb;
   logic              mem_regceb;
   logic [ADDR_W-1:0] mem_addrb;
   logic [DATA_W-1:0] mem_doutb;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;
   logic              par_err;

   modport master (
      input  start, base_addr, length, mem_doutb, m_tready,
      output busy, done, mem_enb, mem_regceb, mem_addrb,
             m_tdata, m_tvalid, m_tlast, par_err
   );

   modport slave (
      output start, base_addr, length, mem_doutb, m_tready,
      input  busy, done, mem_enb, mem_regceb, mem_addrb,
             m_tdata, m_tvalid, m_tlast, par_err
   );
endinterface

// File: rtl/uram_stream_reader.sv
// Reads a contiguous run of UltraRAM words through port B and streams them out via a credit-limited FIFO.
// Optional read-parity checker enabled by defining URAM_RD_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for start; only state with busy=0
// ISSUE  | issuing reads while credits allow
// DRAIN  | all reads issued, waiting for the last beat to be accepted
// FINISH | one-cycle done pulse
module uram_stream_reader #(
   parameter int ADDR_W     = 21,
   parameter int DATA_W     = 72,
   parameter int RD_LAT     = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clkb_i,
   input  logic                  rstb_i,
   uram_stream_reader_if.master  bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   issue_rem_q, issue_rem_d;
   logic [ADDR_W:0]   beat_rem_q, beat_rem_d;
   logic              enb_q, enb_d;
   logic              regceb_q;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [RD_LAT-1:0] sr_q, sr_d;
   logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  out_q, out_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              wr_en, pop, accept;

   assign wr_en  = sr_q[RD_LAT-1];
   assign pop    = valid_q & bus.m_tready;
   assign accept = (state_q == IDLE) & bus.start;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      issue_rem_d = issue_rem_q;
      beat_rem_d  = beat_rem_q;
      enb_d       = 1'b0;
      sr_d        = sr_q << 1;
      sr_d[0]     = enb_q;
      cnt_d       = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
      // out counts reads issued but not yet consumed: in flight plus FIFO occupancy
      out_d       = out_q + CNT_W'(enb_q) - CNT_W'(pop);

      if (enb_q) begin
         addr_d      = addr_q + ADDR_W'(1);
         issue_rem_d = issue_rem_q - (ADDR_W+1)'(1);
      end
      if (pop) beat_rem_d = beat_rem_q - (ADDR_W+1)'(1);

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d      = bus.base_addr;
               issue_rem_d = bus.length;
               beat_rem_d  = bus.length;
               if (bus.length == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d = ISSUE;
                  enb_d   = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (issue_rem_d == '0) state_d = DRAIN;
            else                   enb_d   = (out_d < CNT_W'(FIFO_DEPTH));
         end
         DRAIN: begin
            if (beat_rem_d == '0) state_d = FINISH;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d != IDLE);
      done_d  = (state_d == FINISH);
      valid_d = (cnt_d != '0);
      last_d  = valid_d & (beat_rem_d == (ADDR_W+1)'(1));
   end

   always_ff @(posedge clkb_i) begin
      if (rstb_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         issue_rem_q <= '0;
         beat_rem_q  <= '0;
         enb_q       <= 1'b0;
         regceb_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sr_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         issue_rem_q <= issue_rem_d;
         beat_rem_q  <= beat_rem_d;
         enb_q       <= enb_d;
         regceb_q    <= 1'b1;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         if (wr_en) begin
            fifo_q[wr_ptr_q] <= bus.mem_doutb;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

`ifdef URAM_RD_PARITY_EN
   logic par_err_q;
   logic par_bad;

   // even parity per byte: byte i together with bit 64+i must XOR to zero
   always_comb begin
      par_bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         par_bad = par_bad | ((^bus.mem_doutb[8*i +: 8]) ^ bus.mem_doutb[64+i]);
      end
   end

   always_ff @(posedge clkb_i) begin
      if (rstb_i)                 par_err_q <= 1'b0;
      else if (wr_en & par_bad)   par_err_q <= 1'b1;
      else if (accept)            par_err_q <= 1'b0;
   end

   assign bus.par_err = par_err_q;
`else
   assign bus.par_err = 1'b0;
`endif

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.mem_enb    = enb_q;
   assign bus.mem_regceb = regceb_q;
   assign bus.mem_addrb  = addr_q;
   assign bus.m_tdata    = fifo_q[rd_ptr_q];
   assign bus.m_tvalid   = valid_q;
   assign bus.m_tlast    = last_q;
endmodule

// File: tb/tb_uram_stream_reader.sv
// Scoreboard bench for uram_stream_reader: directed transfers against a latency-RD_LAT memory model.
module tb_uram_stream_reader;
   localparam int ADDR_W = 21;
   localparam int DATA_W = 72;
   localparam int RD_LAT = 3;
   localparam int DEPTH  = 8;
`ifdef URAM_RD_PARITY_EN
   localparam bit EXP_PE = 1'b1;
`else
   localparam bit EXP_PE = 1'b0;
`endif

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              l;
   } beat_t;

   logic clkb = 1'b0;
   logic rstb = 1'b1;
   always #5 clkb = ~clkb;

   uram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   uram_stream_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clkb_i(clkb),
      .rstb_i(rstb),
      .bus   (bus)
   );

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   always @(posedge clkb) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a, input bit bad_en,
                                                 input logic [ADDR_W-1:0] bad_a);
      logic [63:0] d;
      logic [7:0]  p;
      logic [DATA_W-1:0] w;
      d = {11'h5a5, a, 11'h3c3, a};
      for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
      w = {p, d};
      if (bad_en && a == bad_a) w[64] = ~w[64];
      return w;
   endfunction

   // memory model: data for a read issued in cycle t is on mem_doutb in cycle t+RD_LAT
   bit                corrupt_en = 1'b0;
   logic [ADDR_W-1:0] corrupt_a  = 21'h155555;
   logic [RD_LAT-1:0] pv = '0;
   logic [ADDR_W-1:0] pa [RD_LAT];
   always @(posedge clkb) begin
      pv    <= {pv[RD_LAT-2:0], bus.mem_enb};
      pa[0] <= bus.mem_addrb;
      for (int k = 1; k < RD_LAT; k++) pa[k] <= pa[k-1];
   end
   assign bus.mem_doutb = pv[RD_LAT-1] ? word_of(pa[RD_LAT-1], corrupt_en, corrupt_a) : '1;

   int rmode = 0;
   int rphase = 0;
   initial begin
      bus.m_tready = 1'b1;
      forever begin
         @(posedge clkb);
         #1;
         rphase++;
         bus.m_tready = (rmode == 0) ? 1'b1 : (rphase % 3 == 0);
      end
   end

   beat_t             exp_q[$];
   logic [ADDR_W-1:0] addr_exp_q[$];
   int  iss_cnt, pop_cnt, max_out, beat_cnt;
   int  first_enb_cyc, first_val_cyc, last_hs_cyc, done_cyc;
   bit  done_seen;

   always @(negedge clkb) begin
      if (!rstb) begin
         if (bus.mem_enb) begin
            iss_cnt++;
            if (first_enb_cyc < 0) first_enb_cyc = cyc;
            if (addr_exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_read: got addr %0h expected no read (cycle %0d)", bus.mem_addrb, cyc);
            end else begin
               chk("mem_addrb", bus.mem_addrb, addr_exp_q.pop_front());
            end
         end
         if (bus.m_tvalid && first_val_cyc < 0) first_val_cyc = cyc;
         if (bus.m_tvalid && bus.m_tready) begin
            pop_cnt++;
            beat_cnt++;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_beat: got data %0h expected no beat (cycle %0d)", bus.m_tdata, cyc);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("m_tdata", bus.m_tdata, e.d);
               chk("m_tlast", DATA_W'(bus.m_tlast), DATA_W'(e.l));
            end
         end
         if (iss_cnt - pop_cnt > max_out) max_out = iss_cnt - pop_cnt;
         if (bus.done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
      end
   end

   task automatic start_xfer(input logic [ADDR_W-1:0] base, input int len, output int sc);
      @(posedge clkb);
      #1;
      first_enb_cyc = -1; first_val_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
      done_seen = 1'b0; iss_cnt = 0; pop_cnt = 0; max_out = 0; beat_cnt = 0;
      for (int i = 0; i < len; i++) begin
         logic [ADDR_W-1:0] a;
         beat_t b;
         a = base + ADDR_W'(i);
         addr_exp_q.push_back(a);
         b.d = word_of(a, corrupt_en, corrupt_a);
         b.l = (i == len - 1);
         exp_q.push_back(b);
      end
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.length    = (ADDR_W+1)'(len);
      sc = cyc;
      @(posedge clkb);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done_seen && n < budget) begin
         @(posedge clkb);
         n++;
      end
      #1;
      chk("done_seen", DATA_W'(done_seen), DATA_W'(1));
      chk("busy_after_done", DATA_W'(bus.busy), '0);
      chk("done_one_cycle", DATA_W'(bus.done), '0);
      chk("queue_empty", DATA_W'(exp_q.size()), '0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, n;
      bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
      first_enb_cyc = -1; first_val_cyc = -1; done_seen = 1'b0;
      iss_cnt = 0; pop_cnt = 0; max_out = 0; beat_cnt = 0;
      rstb = 1'b1;
      repeat (3) @(posedge clkb);
      #1 rstb = 1'b0;
      chk("rst_busy", DATA_W'(bus.busy), '0);
      chk("rst_enb", DATA_W'(bus.mem_enb), '0);
      chk("rst_regceb", DATA_W'(bus.mem_regceb), '0);
      chk("rst_tvalid", DATA_W'(bus.m_tvalid), '0);
      chk("rst_tdata", bus.m_tdata, '0);
      chk("rst_par_err", DATA_W'(bus.par_err), '0);
      @(posedge clkb); #1;
      chk("regceb_run", DATA_W'(bus.mem_regceb), DATA_W'(1));

      // basic 16-word transfer with timing
      start_xfer(21'h00010, 16, sc);
      chk("busy_c1", DATA_W'(bus.busy), DATA_W'(1));
      chk("enb_c1", DATA_W'(bus.mem_enb), DATA_W'(1));
      wait_done(200);
      chk("first_enb_lat", DATA_W'(first_enb_cyc - sc), DATA_W'(1));
      chk("first_valid_lat", DATA_W'(first_val_cyc - sc), DATA_W'(5));
      chk("done_after_last", DATA_W'(done_cyc - last_hs_cyc), DATA_W'(1));
      chk("beats_16", DATA_W'(beat_cnt), DATA_W'(16));
      chk("done_cycle_16", DATA_W'(done_cyc - sc), DATA_W'(21));

      // address wrap at all-ones
      start_xfer(21'h1FFFFE, 4, sc);
      wait_done(100);
      chk("beats_wrap", DATA_W'(beat_cnt), DATA_W'(4));

      // zero length
      start_xfer(21'h00123, 0, sc);
      chk("len0_done_c1", DATA_W'(bus.done), DATA_W'(1));
      chk("len0_busy_c1", DATA_W'(bus.busy), DATA_W'(1));
      @(posedge clkb); #1;
      chk("len0_done_c2", DATA_W'(bus.done), '0);
      chk("len0_busy_c2", DATA_W'(bus.busy), '0);
      repeat (8) @(posedge clkb);
      #1;
      chk("len0_no_reads", DATA_W'(iss_cnt), '0);
      chk("len0_no_valid", DATA_W'(first_val_cyc), DATA_W'(-1));

      // back-pressure: ready 1 cycle in 3, credits must saturate at DEPTH
      rmode = 1;
      start_xfer(21'h00100, 64, sc);
      wait_done(1000);
      chk("beats_64", DATA_W'(beat_cnt), DATA_W'(64));
      chk("max_outstanding", DATA_W'(max_out), DATA_W'(DEPTH));
      rmode = 0;

      // reset mid-transfer after 5 beats
      start_xfer(21'h00200, 20, sc);
      n = 0;
      while (beat_cnt < 5 && n < 100) begin
         @(posedge clkb); #1;
         n++;
      end
      rstb = 1'b1;
      @(posedge clkb); #1;
      rstb = 1'b0;
      chk("mid_rst_busy", DATA_W'(bus.busy), '0);
      chk("mid_rst_done", DATA_W'(bus.done), '0);
      chk("mid_rst_enb", DATA_W'(bus.mem_enb), '0);
      chk("mid_rst_regceb", DATA_W'(bus.mem_regceb), '0);
      chk("mid_rst_addrb", DATA_W'(bus.mem_addrb), '0);
      chk("mid_rst_tvalid", DATA_W'(bus.m_tvalid), '0);
      chk("mid_rst_tlast", DATA_W'(bus.m_tlast), '0);
      chk("mid_rst_tdata", bus.m_tdata, '0);
      chk("mid_rst_par_err", DATA_W'(bus.par_err), '0);
      exp_q.delete();
      addr_exp_q.delete();
      repeat (10) @(posedge clkb);
      #1;
      chk("beats_before_rst", DATA_W'(beat_cnt), DATA_W'(5));
      start_xfer(21'h00300, 2, sc);
      wait_done(100);
      chk("beats_after_rst", DATA_W'(beat_cnt), DATA_W'(2));

      // parity: word 3 of 8 has bit 64 flipped
      corrupt_en = 1'b1;
      corrupt_a  = 21'h00403;
      start_xfer(21'h00400, 8, sc);
      wait_done(100);
      chk("par_err_held", DATA_W'(bus.par_err), DATA_W'(EXP_PE));
      corrupt_en = 1'b0;
      start_xfer(21'h00500, 1, sc);
      chk("par_err_cleared", DATA_W'(bus.par_err), '0);
      wait_done(100);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
